snow64_lar_mem_bridge: RTL

SNOW64_LAR_MEM_BRIDGE -- requirements
Module: snow64_lar_mem_bridge

---
 rtl/snow64_lar_mem_bridge.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/snow64_lar_mem_bridge.sv
// Bridges LAR line fills and writebacks onto a 64-bit beat-oriented memory bus.
// A writeback accepted together with (or ahead of) a fill is always drained first.
module snow64_lar_mem_bridge #(
    parameter int BASE_ADDR_WIDTH = 59,
    parameter int LINE_WIDTH      = 256,
    parameter int BEAT_WIDTH      = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_rd_req,
    input  logic [BASE_ADDR_WIDTH-1:0] in_rd_base_addr,
    output logic                       out_rd_valid,
    output logic                       out_rd_busy,
    output logic [LINE_WIDTH-1:0]      out_rd_data,
    input  logic                       in_wr_req,
    input  logic [BASE_ADDR_WIDTH-1:0] in_wr_base_addr,
    input  logic [LINE_WIDTH-1:0]      in_wr_data,
    output logic                       out_wr_valid,
    output logic                       out_wr_busy,
    output logic                       out_mem_req,
    output logic                       out_mem_we,
    output logic [63:0]                out_mem_addr,
    output logic [BEAT_WIDTH-1:0]      out_mem_wdata,
    input  logic                       in_mem_ack,
    input  logic [BEAT_WIDTH-1:0]      in_mem_rdata
);

    typedef enum logic [1:0] {
        Idle          = 2'd0,
        Write         = 2'd1,
        Read          = 2'd2,
        WriteThenRead = 2'd3
    } stateT;

    stateT                      state, stateNext;
    logic [1:0]                 beat, beatNext;
    logic [BASE_ADDR_WIDTH-1:0] rdBase, rdBaseNext;
    logic [BASE_ADDR_WIDTH-1:0] wrBase, wrBaseNext;
    logic [LINE_WIDTH-1:0]      wrLine, wrLineNext;
    logic [LINE_WIDTH-1:0]      rdLineNext;
    logic                       rdValidNext, wrValidNext;
    logic                       rdBusyNext, wrBusyNext;
    logic                       memReqNext, memWeNext;
    logic [63:0]                memAddrNext;
    logic [BEAT_WIDTH-1:0]      memWdataNext;
    logic                       beatDone, lastBeat, acceptRd;

    // Next-state, datapath capture and next values of every registered output.
    always_comb begin
        stateNext    = state;
        beatNext     = beat;
        rdBaseNext   = rdBase;
        wrBaseNext   = wrBase;
        wrLineNext   = wrLine;
        rdLineNext   = out_rd_data;
        rdValidNext  = 1'b0;
        wrValidNext  = 1'b0;
        rdBusyNext   = out_rd_busy;
        wrBusyNext   = out_wr_busy;
        memReqNext   = 1'b0;
        memWeNext    = 1'b0;
        memAddrNext  = out_mem_addr;
        memWdataNext = out_mem_wdata;

        // ack only counts while a beat is actually outstanding
        beatDone = out_mem_req && in_mem_ack;
        lastBeat = beatDone && (beat == 2'd3);
        acceptRd = (state == Write) && in_rd_req && !out_rd_busy;

        case (state)
            Idle: begin
                if (in_wr_req && in_rd_req) begin
                    wrBaseNext = in_wr_base_addr;
                    wrLineNext = in_wr_data;
                    wrBusyNext = 1'b1;
                    rdBaseNext = in_rd_base_addr;
                    rdBusyNext = 1'b1;
                    beatNext   = 2'd0;
                    stateNext  = WriteThenRead;
                end else if (in_wr_req) begin
                    wrBaseNext = in_wr_base_addr;
                    wrLineNext = in_wr_data;
                    wrBusyNext = 1'b1;
                    beatNext   = 2'd0;
                    stateNext  = Write;
                end else if (in_rd_req) begin
                    rdBaseNext = in_rd_base_addr;
                    rdBusyNext = 1'b1;
                    beatNext   = 2'd0;
                    stateNext  = Read;
                end else begin
                    stateNext = Idle;
                end
            end
            Write, WriteThenRead: begin
                if (acceptRd) begin
                    rdBaseNext = in_rd_base_addr;
                    rdBusyNext = 1'b1;
                end else begin
                    rdBaseNext = rdBase;
                end
                if (lastBeat) begin
                    wrValidNext = 1'b1;
                    wrBusyNext  = 1'b0;
                    beatNext    = 2'd0;
                    stateNext   = ((state == WriteThenRead) || acceptRd) ? Read : Idle;
                end else if (beatDone) begin
                    beatNext  = beat + 2'd1;
                    stateNext = acceptRd ? WriteThenRead : state;
                end else begin
                    stateNext = acceptRd ? WriteThenRead : state;
                end
            end
            Read: begin
                if (beatDone) begin
                    rdLineNext[int'(beat)*BEAT_WIDTH +: BEAT_WIDTH] = in_mem_rdata;
                end else begin
                    rdLineNext = out_rd_data;
                end
                if (lastBeat) begin
                    rdValidNext = 1'b1;
                    rdBusyNext  = 1'b0;
                    beatNext    = 2'd0;
                    stateNext   = Idle;
                end else if (beatDone) begin
                    beatNext = beat + 2'd1;
                end else begin
                    beatNext = beat;
                end
            end
            default: begin
                stateNext = Idle;
                beatNext  = 2'd0;
            end
        endcase

        // Bus fields derive from the upcoming state so they stay put while a beat waits.
        if (stateNext != Idle) begin
            memReqNext = 1'b1;
            memWeNext  = (stateNext != Read);
            if (memWeNext) begin
                memAddrNext  = {wrBaseNext, beatNext, 3'b000};
                memWdataNext = wrLineNext[int'(beatNext)*BEAT_WIDTH +: BEAT_WIDTH];
            end else begin
                memAddrNext  = {rdBaseNext, beatNext, 3'b000};
                memWdataNext = out_mem_wdata;
            end
        end else begin
            memReqNext = 1'b0;
            memWeNext  = 1'b0;
        end
    end

    // State, latched request data and all outputs, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= Idle;
            beat          <= 2'd0;
            rdBase        <= '0;
            wrBase        <= '0;
            wrLine        <= '0;
            out_rd_data   <= '0;
            out_rd_valid  <= 1'b0;
            out_wr_valid  <= 1'b0;
            out_rd_busy   <= 1'b0;
            out_wr_busy   <= 1'b0;
            out_mem_req   <= 1'b0;
            out_mem_we    <= 1'b0;
            out_mem_addr  <= 64'd0;
            out_mem_wdata <= '0;
        end else begin
            state         <= stateNext;
            beat          <= beatNext;
            rdBase        <= rdBaseNext;
            wrBase        <= wrBaseNext;
            wrLine        <= wrLineNext;
            out_rd_data   <= rdLineNext;
            out_rd_valid  <= rdValidNext;
            out_wr_valid  <= wrValidNext;
            out_rd_busy   <= rdBusyNext;
            out_wr_busy   <= wrBusyNext;
            out_mem_req   <= memReqNext;
            out_mem_we    <= memWeNext;
            out_mem_addr  <= memAddrNext;
            out_mem_wdata <= memWdataNext;
        end
    end

endmodule
